// File: rtl/cpu_pkg.sv
// Shared constants, the O/E latch record and small helpers for the operand stage.
package cpu_pkg;

    localparam int unsigned REG_AW    = 6;
    localparam int unsigned NREGS     = 64;
    // The latch record carries the opcode at a fixed maximum width; the stage
    // narrows it to its own OPC_W parameter.
    localparam int unsigned OPC_MAX_W = 16;
    localparam int unsigned NOP_OPC   = 0;
    localparam int unsigned CNT_W     = 16;

    typedef struct packed {
        logic                 valid;
        logic [OPC_MAX_W-1:0] opcode;
        logic [REG_AW-1:0]    ra;
        logic [REG_AW-1:0]    rb;
        logic [REG_AW-1:0]    rc;
        logic                 read;
        logic                 write;
    } latch_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Decode, write-back, hazard-unit and execute signals of the operand stage.
interface operand_stage_if
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OPC_W  = 6
);

    // Decode side
    logic              dec_valid;
    logic [OPC_W-1:0]  dec_opcode;
    logic [REG_AW-1:0] dec_ra;
    logic [REG_AW-1:0] dec_rb;
    logic [REG_AW-1:0] dec_rc;
    logic              dec_read;
    logic              dec_write;
    logic              dec_ready;

    // Write-back side
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    // Hazard unit
    logic              hold_registers;
    logic              TreadOperand;
    logic [REG_AW-1:0] operandAbus;
    logic [REG_AW-1:0] operandBbus;
    logic              TwriteExecute;
    logic [REG_AW-1:0] executeCbus;

    // Execute side
    logic              ex_valid;
    logic [OPC_W-1:0]  ex_opcode;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [REG_AW-1:0] ex_rc;
    logic              ex_write;

    // Surrounding pipeline: decode, write-back and hazard unit.
    modport master (
        output dec_valid, dec_opcode, dec_ra, dec_rb, dec_rc, dec_read, dec_write,
        output wb_en, wb_addr, wb_data, hold_registers,
        input  dec_ready, TreadOperand, operandAbus, operandBbus, TwriteExecute,
        input  executeCbus, ex_valid, ex_opcode, ex_a, ex_b, ex_rc, ex_write
    );

    // The operand stage itself.
    modport slave (
        input  dec_valid, dec_opcode, dec_ra, dec_rb, dec_rc, dec_read, dec_write,
        input  wb_en, wb_addr, wb_data, hold_registers,
        output dec_ready, TreadOperand, operandAbus, operandBbus, TwriteExecute,
        output executeCbus, ex_valid, ex_opcode, ex_a, ex_b, ex_rc, ex_write
    );

endinterface

// File: rtl/regfile_2r1w.sv
// 64-entry register file: two combinational read ports with write-back bypass,
// one write port, register 0 hard-wired to zero, asynchronous clear.
module regfile_2r1w
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] ra_addr_i,
    input  logic [REG_AW-1:0] rb_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [NREGS];

    // Write port; writes to r0 are dropped so it stays zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports: r0 reads zero, a same-cycle write to the address bypasses the file.
    always_comb begin
        ra_data_o = '0;
        rb_data_o = '0;
        if (ra_addr_i != '0) begin
            ra_data_o = (we_i && (waddr_i == ra_addr_i)) ? wdata_i : mem_q[ra_addr_i];
        end
        if (rb_addr_i != '0) begin
            rb_data_o = (we_i && (waddr_i == rb_addr_i)) ? wdata_i : mem_q[rb_addr_i];
        end
    end

endmodule

// File: rtl/operand_stage.sv
// Operand-fetch stage: O latch, register read with bypass, E latch, stall
// qualification for the hazard unit and a saturating stall counter.
module operand_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OPC_W  = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    operand_stage_if.slave   bus,
    output logic [CNT_W-1:0] stall_count
);

    latch_t            o_q, o_d;
    logic              ex_valid_q, ex_valid_d;
    logic              ex_write_q, ex_write_d;
    logic [OPC_W-1:0]  ex_opc_q, ex_opc_d;
    logic [REG_AW-1:0] ex_rc_q, ex_rc_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              stall;

    regfile_2r1w #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .reset_n   (reset_n),
        .ra_addr_i (o_q.ra),
        .rb_addr_i (o_q.rb),
        .ra_data_o (rd_a),
        .rb_data_o (rd_b),
        .we_i      (bus.wb_en),
        .waddr_i   (bus.wb_addr),
        .wdata_i   (bus.wb_data)
    );

    assign bus.TreadOperand  = o_q.valid & o_q.read;
    assign bus.operandAbus   = o_q.ra;
    assign bus.operandBbus   = o_q.rb;
    assign bus.TwriteExecute = ex_valid_q & ex_write_q;
    assign bus.executeCbus   = ex_rc_q;

    // hold_registers is stale whenever the hazard unit has nothing to compare,
    // so it only counts while O reads and E writes.
    assign stall         = bus.hold_registers & bus.TreadOperand & bus.TwriteExecute;
    assign bus.dec_ready = ~stall;

    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_write  = ex_write_q;
    assign bus.ex_opcode = ex_opc_q;
    assign bus.ex_rc     = ex_rc_q;
    assign bus.ex_a      = ex_a_q;
    assign bus.ex_b      = ex_b_q;
    assign stall_count   = cnt_q;

    // O latch next state: load decode unless stalled; an empty slot empties O.
    always_comb begin
        o_d = o_q;
        if (!stall) begin
            o_d.valid  = bus.dec_valid;
            o_d.opcode = OPC_MAX_W'(bus.dec_opcode);
            o_d.ra     = bus.dec_ra;
            o_d.rb     = bus.dec_rb;
            o_d.rc     = bus.dec_rc;
            o_d.read   = bus.dec_read;
            o_d.write  = bus.dec_write;
        end
    end

    // E latch and counter next state: stall or empty O produce an all-zero bubble.
    always_comb begin
        ex_valid_d = 1'b0;
        ex_write_d = 1'b0;
        ex_opc_d   = OPC_W'(NOP_OPC);
        ex_rc_d    = '0;
        ex_a_d     = '0;
        ex_b_d     = '0;
        cnt_d      = cnt_q;
        if (stall) begin
            cnt_d = sat_inc(cnt_q);
        end else if (o_q.valid) begin
            ex_valid_d = 1'b1;
            ex_write_d = o_q.write;
            ex_opc_d   = OPC_W'(o_q.opcode);
            ex_rc_d    = o_q.rc;
            if (o_q.read) begin
                ex_a_d = rd_a;
                ex_b_d = rd_b;
            end
        end
    end

    // O latch register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_q <= '0;
        end else begin
            o_q <= o_d;
        end
    end

    // E latch register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q <= 1'b0;
            ex_write_q <= 1'b0;
            ex_opc_q   <= OPC_W'(NOP_OPC);
            ex_rc_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_write_q <= ex_write_d;
            ex_opc_q   <= ex_opc_d;
            ex_rc_q    <= ex_rc_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
